// File: rtl/tmem_pkg.sv
// Shared types for the tagged-memory slave: controller states and captured request kinds.
package tmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    BUSY   = 2'd2,
    LOCKED = 2'd3
  } tmem_state_t;

  typedef enum logic [1:0] {
    REQ_RD  = 2'd0,
    REQ_WR  = 2'd1,
    REQ_BAD = 2'd2
  } req_kind_t;

  localparam int WAIT_MAX = 15;

endpackage

// File: rtl/tmem_array.sv
// Single-port synchronous RAM holding {tag, data} per word; registered read output.
module tmem_array #(
  parameter int DEPTH = 1024,
  parameter int W     = 72,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Read output only moves on a read, so it stays valid through the wait cycles.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/tmem_ctrl.sv
// Tagged-memory bus slave: address/request handshake, programmable wait states,
// range/protocol error reporting and an atomic read-modify-write lock.
module tmem_ctrl
  import tmem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8,
  parameter int ADDR_W = 20,
  parameter int DEPTH  = 1048576,
  parameter int WAIT   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] i_ad,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_astb,
  input  logic              i_atomic,
  input  logic              i_rd,
  input  logic              i_wr,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_ack,
  output logic              o_err,
  output logic              o_locked
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MW = DATA_W + TAG_W;
  localparam logic [3:0] WAIT_CNT = 4'((WAIT > WAIT_MAX) ? WAIT_MAX : WAIT);

  tmem_state_t       r_state, w_state_nx;
  logic [ADDR_W-1:0] r_addr;
  logic              r_atomic;
  req_kind_t         r_kind, w_kind;
  logic [DATA_W-1:0] r_wdata;
  logic [TAG_W-1:0]  r_wtag;
  logic [3:0]        r_cnt;
  logic              w_latch, w_capture, w_done, w_ram_re, w_ram_we;
  logic              w_in_range, w_ok;
  logic [MW-1:0]     w_ram_q;

  assign w_in_range = ({1'b0, r_addr} < (ADDR_W+1)'(DEPTH));
  assign w_ok       = (r_kind != REQ_BAD) && w_in_range;
  assign w_ram_we   = w_done && w_ok && (r_kind == REQ_WR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_latch    = 1'b0;
    w_capture  = 1'b0;
    w_done     = 1'b0;
    w_ram_re   = 1'b0;
    w_kind     = REQ_RD;
    unique case (r_state)
      IDLE: begin
        if (i_astb) begin
          w_latch    = 1'b1;
          w_state_nx = ADDR;
        end
      end
      // LOCKED shares the ADDR decode: the held address is simply reused.
      ADDR, LOCKED: begin
        if (i_astb) begin
          w_latch    = 1'b1;
          w_state_nx = ADDR;
        end else if (i_rd || i_wr) begin
          w_capture  = 1'b1;
          w_state_nx = BUSY;
          w_ram_re   = i_rd && !i_wr;
          if (i_rd && i_wr) w_kind = REQ_BAD;
          else if (i_rd)    w_kind = REQ_RD;
          else              w_kind = REQ_WR;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_done     = 1'b1;
          w_state_nx = (w_ok && r_atomic && r_kind == REQ_RD) ? LOCKED : IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr   <= '0;
      r_atomic <= 1'b0;
      r_kind   <= REQ_RD;
      r_wdata  <= '0;
      r_wtag   <= '0;
      r_cnt    <= '0;
      o_data   <= '0;
      o_tag    <= '0;
      o_ack    <= 1'b0;
      o_err    <= 1'b0;
      o_locked <= 1'b0;
    end else begin
      o_ack <= 1'b0;
      o_err <= 1'b0;
      if (w_latch) begin
        r_addr   <= i_ad[ADDR_W-1:0];
        r_atomic <= i_atomic;
        o_locked <= 1'b0;
      end
      if (w_capture) begin
        r_kind  <= w_kind;
        r_wdata <= i_ad;
        r_wtag  <= i_tag;
        r_cnt   <= WAIT_CNT;
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done) begin
        o_ack    <= 1'b1;
        o_err    <= !w_ok;
        o_locked <= (w_state_nx == LOCKED);
        if (r_kind == REQ_RD) begin
          o_data <= w_ok ? w_ram_q[DATA_W-1:0] : '0;
          o_tag  <= w_ok ? w_ram_q[MW-1:DATA_W] : '0;
        end
      end
    end
  end

  tmem_array #(
    .DEPTH (DEPTH),
    .W     (MW),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (r_addr[AW-1:0]),
    .i_wdata ({r_wtag, r_wdata}),
    .o_rdata (w_ram_q)
  );

endmodule

// File: tb/tb_tmem_ctrl.sv
// Directed bench for tmem_ctrl: three instances (WAIT=0/3/5, DEPTH=1024) with
// inputs steered to the instance selected by sel.
module tb_tmem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] ad = '0;
  logic [7:0]  tag = '0;
  logic        astb = 1'b0, atomic = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [1:0]  sel = 2'd0;

  logic [2:0]  v_astb, v_atomic, v_rd, v_wr, v_ack, v_err, v_locked;
  logic [63:0] v_data [3];
  logic [7:0]  v_tag  [3];

  logic [63:0] obs_data;
  logic [7:0]  obs_tag;
  logic        obs_ack, obs_err, obs_locked;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign v_astb[k]   = astb   && (sel == 2'(k));
    assign v_atomic[k] = atomic && (sel == 2'(k));
    assign v_rd[k]     = rd     && (sel == 2'(k));
    assign v_wr[k]     = wr     && (sel == 2'(k));
    tmem_ctrl #(
      .DATA_W (64), .TAG_W (8), .ADDR_W (20), .DEPTH (1024),
      .WAIT   ((k == 0) ? 0 : (k == 1) ? 3 : 5)
    ) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_ad     (ad),
      .i_tag    (tag),
      .i_astb   (v_astb[k]),
      .i_atomic (v_atomic[k]),
      .i_rd     (v_rd[k]),
      .i_wr     (v_wr[k]),
      .o_data   (v_data[k]),
      .o_tag    (v_tag[k]),
      .o_ack    (v_ack[k]),
      .o_err    (v_err[k]),
      .o_locked (v_locked[k])
    );
  end

  always_comb begin
    obs_data   = v_data[sel];
    obs_tag    = v_tag[sel];
    obs_ack    = v_ack[sel];
    obs_err    = v_err[sel];
    obs_locked = v_locked[sel];
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic strobe(input logic [63:0] a, input logic at);
    ad = a; astb = 1'b1; atomic = at;
    @(negedge clk);
    astb = 1'b0; atomic = 1'b0; ad = '0;
  endtask

  task automatic xfer(input logic w, input logic r, input logic [63:0] d, input logic [7:0] t,
                      output int lat, output bit chg);
    logic [63:0] snap;
    snap = obs_data; chg = 1'b0; lat = -1;
    wr = w; rd = r; ad = d; tag = t;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; ad = '0; tag = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (obs_ack) begin lat = k; break; end
      if (obs_data !== snap) chg = 1'b1;
    end
  endtask

  task automatic quiet(input int n, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (obs_ack) seen = 1'b1;
    end
  endtask

  initial begin
    int lat;
    bit chg, seen;

    @(negedge clk); @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #0;
      chk("rst_ack", obs_ack, 0);
      chk("rst_data", obs_data, 0);
      chk("rst_locked", obs_locked, 0);
    end
    sel = 2'd0;
    reset_n = 1'b1;
    @(negedge clk);

    // WAIT=0 basic write/read
    strobe(64'd0, 1'b0); xfer(1, 0, 64'hAAAA_0000_1111_2222, 8'h11, lat, chg);
    chk("w0_setup_lat", 64'(lat), 1);
    strobe(64'd5, 1'b0); xfer(1, 0, 64'h0123_4567_89AB_CDEF, 8'h3C, lat, chg);
    chk("w0_wr_lat", 64'(lat), 1);
    chk("w0_wr_err", obs_err, 0);
    @(negedge clk);
    chk("w0_ack_pulse", obs_ack, 0);
    strobe(64'd5, 1'b0); xfer(0, 1, '0, '0, lat, chg);
    chk("w0_rd_lat", 64'(lat), 1);
    chk("w0_rd_data", obs_data, 64'h0123_4567_89AB_CDEF);
    chk("w0_rd_tag", obs_tag, 8'h3C);
    chk("w0_rd_err", obs_err, 0);

    // Out of range
    strobe(64'd1024, 1'b0); xfer(1, 0, 64'hFF, 8'hFF, lat, chg);
    chk("oor_wr_lat", 64'(lat), 1);
    chk("oor_wr_err", obs_err, 1);
    @(negedge clk);
    chk("oor_err_pulse", obs_err, 0);
    strobe(64'd0, 1'b0); xfer(0, 1, '0, '0, lat, chg);
    chk("oor_addr0_data", obs_data, 64'hAAAA_0000_1111_2222);
    chk("oor_addr0_tag", obs_tag, 8'h11);
    strobe(64'd1024, 1'b0); xfer(0, 1, '0, '0, lat, chg);
    chk("oor_rd_err", obs_err, 1);
    chk("oor_rd_data", obs_data, 0);
    chk("oor_rd_tag", obs_tag, 0);
    chk("oor_rd_locked", obs_locked, 0);

    // Atomic read then write without strobe
    strobe(64'd7, 1'b1); xfer(0, 1, '0, '0, lat, chg);
    chk("at_rd_lat", 64'(lat), 1);
    chk("at_locked", obs_locked, 1);
    @(negedge clk);
    chk("at_locked_hold", obs_locked, 1);
    xfer(1, 0, 64'h55, 8'h5A, lat, chg);
    chk("at_wr_lat", 64'(lat), 1);
    chk("at_wr_unlock", obs_locked, 0);
    strobe(64'd7, 1'b0); xfer(0, 1, '0, '0, lat, chg);
    chk("at_addr7", obs_data, 64'h55);
    chk("at_addr7_tag", obs_tag, 8'h5A);

    // Atomic lock released by a new strobe
    strobe(64'd7, 1'b1); xfer(0, 1, '0, '0, lat, chg);
    chk("rel_locked", obs_locked, 1);
    strobe(64'd9, 1'b0);
    chk("rel_unlock", obs_locked, 0);
    xfer(1, 0, 64'h66, 8'h09, lat, chg);
    chk("rel_wr_lat", 64'(lat), 1);
    strobe(64'd9, 1'b0); xfer(0, 1, '0, '0, lat, chg);
    chk("rel_addr9", obs_data, 64'h66);
    strobe(64'd7, 1'b0); xfer(0, 1, '0, '0, lat, chg);
    chk("rel_addr7", obs_data, 64'h55);

    // Protocol error: rd and wr together
    strobe(64'd5, 1'b0); xfer(1, 1, 64'hDEAD_BEEF, 8'hEE, lat, chg);
    chk("pe_lat", 64'(lat), 1);
    chk("pe_err", obs_err, 1);
    @(negedge clk);
    chk("pe_ack_pulse", obs_ack, 0);
    rd = 1'b1; @(negedge clk); rd = 1'b0;
    quiet(4, seen);
    chk("pe_idle", seen, 0);
    strobe(64'd5, 1'b0); xfer(0, 1, '0, '0, lat, chg);
    chk("pe_mem", obs_data, 64'h0123_4567_89AB_CDEF);

    // WAIT=3 latency and hold
    sel = 2'd1;
    strobe(64'd5, 1'b0); xfer(1, 0, 64'h0123_4567_89AB_CDEF, 8'h3C, lat, chg);
    chk("w3_wr_lat", 64'(lat), 4);
    strobe(64'd6, 1'b0); xfer(1, 0, 64'h6666_7777, 8'h66, lat, chg);
    strobe(64'd6, 1'b0); xfer(0, 1, '0, '0, lat, chg);
    chk("w3_rd6", obs_data, 64'h6666_7777);
    strobe(64'd5, 1'b0); xfer(0, 1, '0, '0, lat, chg);
    chk("w3_rd_lat", 64'(lat), 4);
    chk("w3_pre_ack_stable", chg, 0);
    chk("w3_rd_data", obs_data, 64'h0123_4567_89AB_CDEF);
    chk("w3_rd_tag", obs_tag, 8'h3C);
    quiet(3, seen);
    chk("w3_no_extra_ack", seen, 0);
    chk("w3_hold", obs_data, 64'h0123_4567_89AB_CDEF);

    // WAIT=5 reset during busy write
    sel = 2'd2;
    strobe(64'd3, 1'b0); xfer(1, 0, 64'h3333, 8'h33, lat, chg);
    chk("w5_wr_lat", 64'(lat), 6);
    strobe(64'd3, 1'b0); xfer(0, 1, '0, '0, lat, chg);
    chk("w5_rd_pre", obs_data, 64'h3333);
    strobe(64'd3, 1'b0);
    wr = 1'b1; ad = 64'h9999; tag = 8'h99;
    @(negedge clk);
    wr = 1'b0; ad = '0; tag = '0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("w5_rst_data", obs_data, 0);
    chk("w5_rst_tag", obs_tag, 0);
    chk("w5_rst_ack", obs_ack, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    quiet(8, seen);
    chk("w5_no_ack", seen, 0);
    strobe(64'd3, 1'b0); xfer(0, 1, '0, '0, lat, chg);
    chk("w5_rd_lat", 64'(lat), 6);
    chk("w5_retained", obs_data, 64'h3333);
    chk("w5_retained_tag", obs_tag, 8'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
